// File: rtl/i2s_tx_pkg.sv
// Shared constants and types for the I2S transmitter slice.
package i2s_tx_pkg;
  localparam logic I2S_MODE_STD = 1'b0;
  localparam logic I2S_MODE_LJ  = 1'b1;

  localparam int unsigned DEFAULT_DW     = 16;
  localparam int unsigned DEFAULT_SLOT_W = 16;

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/i2s_tx_if.sv
// Parallel stereo sample handshake into the I2S transmitter.
interface i2s_tx_if
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
);
  logic [DW-1:0] in_left;
  logic [DW-1:0] in_right;
  logic          in_valid;
  logic          in_ready;

  modport master (output in_left, in_right, in_valid, input in_ready);
  modport slave  (input in_left, in_right, in_valid, output in_ready);
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV cycles while running and
// strobes shift_o on bclk falling edges and on the run-entry cycle.
module i2s_bclk_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic start_i,
  output logic bclk_o,
  output logic shift_o
);
  localparam int unsigned   CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          tick;

  always_comb begin
    tick   = en_i && (div_q == DIV_LAST);
    div_d  = '0;
    bclk_d = 1'b0;
    if (en_i) begin
      div_d  = tick ? '0 : div_q + CW'(1);
      bclk_d = tick ? ~bclk_q : bclk_q;
    end
  end

  assign shift_o = start_i | (tick & bclk_q);
  assign bclk_o  = bclk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-entry holding register feeding a frame register
// that is serialised MSB-first in standard I2S or left-justified timing.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DW      = DEFAULT_DW,
  parameter int unsigned SLOT_W  = DEFAULT_SLOT_W,
  parameter int unsigned CLK_DIV = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     ws_align,
  i2s_tx_if.slave  in_if,
  output logic     i2s_bclk,
  output logic     i2s_ws,
  output logic     i2s_sd,
  output logic     frame_start,
  output logic     underrun
);
  localparam int unsigned   FRAME_W = 2 * SLOT_W;
  localparam int unsigned   PW      = $clog2(FRAME_W);
  localparam int unsigned   FW      = $clog2(2 * DW);
  localparam logic [PW-1:0] P_LAST  = PW'(FRAME_W - 1);
  localparam logic [PW-1:0] SLOT_P  = PW'(SLOT_W);

  state_e          state_q, state_d;
  logic [2*DW-1:0] hold_q, hold_d, frame_q, frame_d;
  logic            full_q, full_d, rdy_q, rdy_d, mode_q, mode_d;
  logic [PW-1:0]   p_q, p_d;
  logic            ws_q, ws_d, sd_q, sd_d, dly_q, dly_d, fs_q, fs_d, ur_q, ur_d;
  logic            run, start, shift, accept, load, lj_bit;

  // Left-justified bit at frame position pos; slot bits past DW are padding.
  function automatic logic lj_at(input logic [2*DW-1:0] fr, input logic [PW-1:0] pos);
    int unsigned   p, idx;
    logic [FW-1:0] bi;
    p   = 32'(pos);
    idx = p % SLOT_W;
    if (idx >= DW) return 1'b0;
    bi = (p < SLOT_W) ? FW'(2 * DW - 1 - idx) : FW'(DW - 1 - idx);
    return fr[bi];
  endfunction

  assign run   = (state_q == RUN) && en;
  assign start = (state_q == IDLE) && en;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .start_i(start),
    .bclk_o (i2s_bclk),
    .shift_o(shift)
  );

  always_comb begin
    accept  = in_if.in_valid & rdy_q;
    load    = start | (run & shift & (p_q == P_LAST));
    state_d = state_q;
    hold_d  = hold_q;
    full_d  = full_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    p_d     = p_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    dly_d   = dly_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    lj_bit  = 1'b0;

    // Load reads the old holding contents before a same-cycle accept refills it.
    if (load) begin
      frame_d = full_q ? hold_q : '0;
      full_d  = 1'b0;
      mode_d  = ws_align;
      fs_d    = 1'b1;
      ur_d    = ~full_q;
    end
    if (accept) begin
      hold_d = {in_if.in_left, in_if.in_right};
      full_d = 1'b1;
    end
    rdy_d = ~full_d;

    if (start) begin
      state_d = RUN;
    end else if (state_q == RUN && !en) begin
      state_d = IDLE;
      p_d     = '0;
      ws_d    = 1'b0;
      sd_d    = 1'b0;
      dly_d   = 1'b0;
    end

    // Standard I2S is the left-justified stream delayed by one shift event.
    if (shift) begin
      p_d    = load ? '0 : p_q + PW'(1);
      lj_bit = lj_at(frame_d, p_d);
      ws_d   = (p_d >= SLOT_P);
      sd_d   = (mode_d == I2S_MODE_LJ) ? lj_bit : dly_q;
      dly_d  = lj_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
      full_q  <= 1'b0;
      rdy_q   <= 1'b0;
      mode_q  <= I2S_MODE_STD;
      p_q     <= '0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      dly_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      full_q  <= full_d;
      rdy_q   <= rdy_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      dly_q   <= dly_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign in_if.in_ready = rdy_q;
  assign i2s_ws         = ws_q;
  assign i2s_sd         = sd_q;
  assign frame_start    = fs_q;
  assign underrun       = ur_q;
endmodule
